// File: rtl/instr_loader.sv
// Byte-serial boot loader: frames a host byte stream into big-endian 32-bit words and writes them to instruction memory.
// Optional trailing checksum byte is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int         DEPTH      = 64,
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] START_BYTE = 8'hFE
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              byte_valid_i,
    input  logic [7:0]        instr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_hold_o
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CKSUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

    state_t            r_state, w_state_next;
    logic [1:0]        r_byte_idx, w_byte_idx_next;
    logic [23:0]       r_asm, w_asm_next;
    logic [ADDR_W:0]   r_count, w_count_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [31:0]       r_data, w_data_next;
    logic [31:0]       w_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor, w_xor_next;
`endif

    assign w_word = {r_asm, instr_i};

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_asm      <= w_asm_next;
            r_count    <= w_count_next;
            r_we       <= w_we_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_xor      <= w_xor_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_asm_next      = r_asm;
        w_count_next    = r_count;
        w_we_next       = 1'b0;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
        w_xor_next      = r_xor;
`endif
        case (r_state)
            S_IDLE: begin
                if (byte_valid_i && (instr_i == START_BYTE)) begin
                    w_state_next    = S_LOAD;
                    w_byte_idx_next = 2'd0;
                    w_asm_next      = 24'd0;
                    w_count_next    = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    w_xor_next      = 8'd0;
`endif
                end
            end
            S_LOAD: begin
                if (byte_valid_i) begin
                    w_asm_next      = w_word[23:0];
                    w_byte_idx_next = r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    // Folding every byte is safe: the four FF terminator bytes cancel to zero.
                    w_xor_next      = r_xor ^ instr_i;
`endif
                    if (r_byte_idx == 2'd3) begin
                        if (w_word == 32'hFFFF_FFFF) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            w_state_next = S_CKSUM;
`else
                            w_state_next = S_DONE;
`endif
                        end else if (r_count == DEPTH_CNT) begin
                            w_state_next = S_ERR;
                        end else begin
                            w_we_next    = 1'b1;
                            w_addr_next  = r_count[ADDR_W-1:0];
                            w_data_next  = w_word;
                            w_count_next = r_count + 1'b1;
                        end
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (byte_valid_i) begin
                    w_state_next = (instr_i == r_xor) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                // DONE and ERR are sticky until reset
                w_state_next = r_state;
            end
        endcase
    end

    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_addr;
    assign imem_data_o  = r_data;
    assign word_count_o = r_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign busy_o       = (r_state == S_LOAD) || (r_state == S_CKSUM);
`else
    assign busy_o       = (r_state == S_LOAD);
`endif
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);
    assign cpu_hold_o   = (r_state != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-depth instance and a DEPTH=4 instance driven by directed and random streams.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, v0, we0, busy0, done0, err0, hold0;
    logic [7:0]  d0;
    logic [5:0]  a0;
    logic [31:0] q0;
    logic [6:0]  c0;

    logic        rst1, v1, we1, busy1, done1, err1, hold1;
    logic [7:0]  d1;
    logic [1:0]  a1;
    logic [31:0] q1;
    logic [2:0]  c1;

    instr_loader dut0 (
        .clk_i(clk), .reset(rst0), .byte_valid_i(v0), .instr_i(d0),
        .imem_we_o(we0), .imem_addr_o(a0), .imem_data_o(q0), .word_count_o(c0),
        .busy_o(busy0), .done_o(done0), .err_o(err0), .cpu_hold_o(hold0)
    );

    instr_loader #(.DEPTH(4), .ADDR_W(2)) dut1 (
        .clk_i(clk), .reset(rst1), .byte_valid_i(v1), .instr_i(d1),
        .imem_we_o(we1), .imem_addr_o(a1), .imem_data_o(q1), .word_count_o(c1),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .cpu_hold_o(hold1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    localparam int P_IDLE = 0, P_LOAD = 1, P_CKSUM = 2, P_DONE = 3, P_ERR = 4;
    int         m_phase [2];
    int         m_words [2];
    int         m_nb    [2];
    logic [7:0] m_buf   [2][4];
    logic [7:0] m_x     [2];
    int         m_depth [2] = '{64, 4};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void model_reset(int s);
        m_phase[s] = P_IDLE;
        m_words[s] = 0;
        m_nb[s]    = 0;
        m_x[s]     = 8'd0;
    endfunction

    // Spec-level model: bytes are grouped in fours; a full word is either the terminator, an overflow, or a write
    function automatic void model_byte(int s, logic [7:0] b, int acc_cyc);
        logic [31:0] w;
        exp_t        e;
        case (m_phase[s])
            P_IDLE: if (b == 8'hFE) begin
                m_phase[s] = P_LOAD; m_nb[s] = 0; m_words[s] = 0; m_x[s] = 8'd0;
            end
            P_LOAD: begin
                m_buf[s][m_nb[s]] = b;
                m_nb[s]++;
                if (m_nb[s] == 4) begin
                    m_nb[s] = 0;
                    w = {m_buf[s][0], m_buf[s][1], m_buf[s][2], m_buf[s][3]};
                    if (w == 32'hFFFF_FFFF) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        m_phase[s] = P_CKSUM;
`else
                        m_phase[s] = P_DONE;
`endif
                    end else begin
                        m_x[s] ^= m_buf[s][0] ^ m_buf[s][1] ^ m_buf[s][2] ^ m_buf[s][3];
                        if (m_words[s] == m_depth[s]) m_phase[s] = P_ERR;
                        else begin
                            e.addr = m_words[s]; e.data = w; e.cyc = acc_cyc;
                            if (s == 0) sb0.push_back(e); else sb1.push_back(e);
                            m_words[s]++;
                        end
                    end
                end
            end
            P_CKSUM: m_phase[s] = (b == m_x[s]) ? P_DONE : P_ERR;
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (we0 === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_write actual addr=%0d data=%h required=no write", a0, q0);
            end else begin
                e = sb0.pop_front();
                chk("dut0_addr", 32'(a0), 32'(e.addr));
                chk("dut0_data", q0, e.data);
                chk("dut0_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (we1 === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_write actual addr=%0d data=%h required=no write", a1, q1);
            end else begin
                e = sb1.pop_front();
                chk("dut1_addr", 32'(a1), 32'(e.addr));
                chk("dut1_data", q1, e.data);
                chk("dut1_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(int s, logic v, logic [7:0] d, logic r);
        if (s == 0) begin v0 = v; d0 = d; rst0 = r; end
        else        begin v1 = v; d1 = d; rst1 = r; end
    endtask

    // Entered and left just after a rising edge; the byte is accepted on the next edge
    task automatic send(int s, logic [7:0] b, int gap);
        drive(s, 1'b1, b, 1'b0);
        model_byte(s, b, cyc + 1);
        @(posedge clk); #1;
        drive(s, 1'b0, 8'($urandom), 1'b0);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(int s, logic [31:0] w, int gap);
        for (int i = 0; i < 4; i++) send(s, w[31-8*i -: 8], gap);
    endtask

    task automatic send_cksum(int s, logic good);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(s, good ? m_x[s] : (m_x[s] ^ 8'h5A), 0);
`else
        if (good && s > 1) send(s, 8'h00, 0);
`endif
    endtask

    task automatic do_reset(int s, logic with_byte);
        drive(s, with_byte, 8'hFE, 1'b1);
        @(posedge clk); #1;
        drive(s, 1'b0, 8'h00, 1'b0);
        model_reset(s);
    endtask

    task automatic check_reset(int s);
        @(negedge clk);
        if (s == 0) begin
            chk("rst0_we", 32'(we0), 0);     chk("rst0_addr", 32'(a0), 0);
            chk("rst0_data", q0, 0);         chk("rst0_count", 32'(c0), 0);
            chk("rst0_busy", 32'(busy0), 0); chk("rst0_done", 32'(done0), 0);
            chk("rst0_err", 32'(err0), 0);   chk("rst0_hold", 32'(hold0), 1);
        end else begin
            chk("rst1_we", 32'(we1), 0);     chk("rst1_count", 32'(c1), 0);
            chk("rst1_done", 32'(done1), 0); chk("rst1_hold", 32'(hold1), 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_final(int s, string tag);
        logic [31:0] ab, ad, ae, ah, ac;
        int qn;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        if (s == 0) begin ab = 32'(busy0); ad = 32'(done0); ae = 32'(err0); ah = 32'(hold0); ac = 32'(c0); qn = sb0.size(); end
        else        begin ab = 32'(busy1); ad = 32'(done1); ae = 32'(err1); ah = 32'(hold1); ac = 32'(c1); qn = sb1.size(); end
        chk({tag, "_busy"}, ab, 32'(m_phase[s] == P_LOAD || m_phase[s] == P_CKSUM));
        chk({tag, "_done"}, ad, 32'(m_phase[s] == P_DONE));
        chk({tag, "_err"},  ae, 32'(m_phase[s] == P_ERR));
        chk({tag, "_hold"}, ah, 32'(m_phase[s] != P_DONE));
        chk({tag, "_count"}, ac, 32'(m_words[s]));
        chk({tag, "_missing_writes"}, 32'(qn), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_session(int s);
        int n;
        do_reset(s, 1'b0);
        repeat ($urandom_range(0, 3)) send(s, 8'($urandom), $urandom_range(0, 1));
        send(s, 8'hFE, $urandom_range(0, 1));
        n = (s == 0) ? $urandom_range(0, 66) : $urandom_range(0, 6);
        for (int i = 0; i < n; i++) send_word(s, $urandom, $urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) begin
            send_word(s, 32'hFFFF_FFFF, $urandom_range(0, 1));
            send_cksum(s, 1'($urandom_range(0, 1)));
        end
        repeat (2) send(s, 8'($urandom), 0);
        check_final(s, "rand");
    endtask

    initial begin
        v0 = 0; d0 = 0; rst0 = 1; v1 = 0; d1 = 0; rst1 = 1;
        model_reset(0); model_reset(1);
        @(posedge clk); #1;
        do_reset(0, 1'b0); check_reset(0);
        do_reset(1, 1'b0); check_reset(1);

        // Two words and terminator, then ignored traffic after completion
        send(0, 8'hFE, 0);
        send_word(0, 32'h0050_0093, 0);
        send_word(0, 32'h00A0_0113, 0);
        send_word(0, 32'hFFFF_FFFF, 0);
        send_cksum(0, 1'b1);
        send(0, 8'hFE, 0); send_word(0, 32'h1122_3344, 0);
        check_final(0, "t1");
        chk("t1_count_const", 32'(c0), 2);
        chk("t1_done_const", 32'(done0), 1);

        // Junk before start byte
        do_reset(0, 1'b0);
        send(0, 8'h12, 0); send(0, 8'h34, 0); send(0, 8'hFF, 0);
        send(0, 8'hFE, 0);
        send_word(0, 32'hDEAD_BEEF, 0);
        send_word(0, 32'hFFFF_FFFF, 0);
        send_cksum(0, 1'b1);
        check_final(0, "t2");

        // Gaps of three idle cycles between every byte
        do_reset(0, 1'b0);
        send(0, 8'hFE, 3);
        send_word(0, 32'h0050_0093, 3);
        send_word(0, 32'h00A0_0113, 3);
        send_word(0, 32'hFFFF_FFFF, 3);
        send_cksum(0, 1'b1);
        check_final(0, "t3");

        // Overflow on the four-word instance
        do_reset(1, 1'b0);
        send(1, 8'hFE, 0);
        for (int i = 0; i < 5; i++) send_word(1, 32'h1000_0000 + 32'(i), 0);
        check_final(1, "t4");
        chk("t4_count_const", 32'(c1), 4);
        chk("t4_err_const", 32'(err1), 1);

        // Reset mid-word, with a start byte presented in the reset cycle
        do_reset(0, 1'b0);
        send(0, 8'hFE, 0); send(0, 8'h00, 0); send(0, 8'h50, 0);
        do_reset(0, 1'b1);
        check_reset(0);
        send(0, 8'hFE, 0);
        send_word(0, 32'h0050_0093, 0);
        send_word(0, 32'hFFFF_FFFF, 0);
        send_cksum(0, 1'b1);
        check_final(0, "t5");

`ifdef INSTR_LOADER_CHECKSUM_EN
        do_reset(0, 1'b0);
        send(0, 8'hFE, 0); send_word(0, 32'h0102_0304, 0); send_word(0, 32'hFFFF_FFFF, 0);
        send(0, 8'h04, 0);
        check_final(0, "ck_good");
        chk("ck_good_done_const", 32'(done0), 1);
        do_reset(0, 1'b0);
        send(0, 8'hFE, 0); send_word(0, 32'h0102_0304, 0); send_word(0, 32'hFFFF_FFFF, 0);
        send(0, 8'h05, 0);
        check_final(0, "ck_bad");
        chk("ck_bad_err_const", 32'(err0), 1);
`endif

        for (int k = 0; k < 10; k++) rand_session(k % 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
